// File: rtl/ap_ctrl_pkg.sv
// Shared types, default parameters and the saturating-increment helper for the
// ap_ctrl_hs initiator.
package ap_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int NUM_W_DEF = 16;
  localparam int CNT_W_DEF = 32;
  localparam int DEPTH_DEF = 4;

  // Increments v but sticks at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] top;
    top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= top) ? top : (v + 64'd1);
  endfunction

endpackage

// File: rtl/ap_ts_fifo.sv
// Issue-timestamp FIFO: DEPTH x W, synchronous, with clear and same-cycle
// push+pop. Head entry is visible on o_data whenever o_empty is low.
module ap_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_push = i_push && (!o_full || i_pop);
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : (r_wr + AW'(1));
      if (w_pop)  r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : (r_rd + AW'(1));
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push && !i_clr) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/ap_ctrl_hs_driver.sv
// ap_ctrl_hs initiator: issues a programmed number of ap_start handshakes with up
// to DEPTH outstanding and records latency/run-time. AP_CTRL_CHAIN_EN enables ap_continue backpressure.
//   state  | meaning
//   IDLE   | waiting for cmd_start; statistics of the last run held
//   RUN    | issuing starts and collecting dones
//   FINISH | one-cycle run_done pulse, then back to IDLE
module ap_ctrl_hs_driver
  import ap_ctrl_pkg::*;
#(
  parameter int NUM_W = NUM_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_cmd_start,
  input  logic [NUM_W-1:0] i_cmd_num,
  output logic             o_ap_start,
  input  logic             i_ap_ready,
  input  logic             i_ap_done,
  output logic             o_ap_continue,
  input  logic             i_cont_allow,
  output logic             o_busy,
  output logic             o_run_done,
  output logic [NUM_W-1:0] o_issued,
  output logic [NUM_W-1:0] o_completed,
  output logic [CNT_W-1:0] o_run_cycles,
  output logic [CNT_W-1:0] o_lat_min,
  output logic [CNT_W-1:0] o_lat_max,
  output logic             o_proto_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NUM_W-1:0] r_num;
  logic [NUM_W-1:0] r_issued;
  logic [NUM_W-1:0] r_completed;
  logic [CNT_W-1:0] r_run_cycles;
  logic [CNT_W-1:0] r_lat_min;
  logic [CNT_W-1:0] r_lat_max;
  logic             r_proto_err;

  logic             w_ap_start;
  logic             w_ap_continue;
  logic             w_clear;
  logic             w_issue_acc;
  logic             w_done_acc;
  logic             w_bypass;
  logic             w_lat_vld;
  logic             w_last;
  logic             w_proto_set;
  logic [CNT_W-1:0] w_lat;
  logic [CNT_W-1:0] w_fifo_q;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_fifo_push;
  logic             w_fifo_pop;

`ifdef AP_CTRL_CHAIN_EN
  assign w_ap_continue = i_cont_allow && (r_state == RUN);
`else
  logic w_unused_cont;
  assign w_ap_continue = 1'b1;
  assign w_unused_cont = i_cont_allow;
`endif

  assign w_clear     = (r_state == IDLE) && i_cmd_start && (i_cmd_num != '0);
  assign w_issue_acc = w_ap_start && i_ap_ready;
  assign w_done_acc  = i_ap_done && w_ap_continue && (r_state == RUN);
  assign w_last      = w_done_acc && ((r_completed + NUM_W'(1)) == r_num);

  // Issue and completion in the same cycle with nothing queued: zero latency,
  // the timestamp never needs to enter the FIFO.
  assign w_bypass    = w_done_acc && w_issue_acc && w_fifo_empty;
  assign w_fifo_push = w_issue_acc && !w_bypass;
  assign w_fifo_pop  = w_done_acc && !w_fifo_empty;
  assign w_lat_vld   = w_done_acc && (!w_fifo_empty || w_issue_acc);
  assign w_lat       = w_bypass ? '0 : (r_run_cycles - w_fifo_q);

  assign w_proto_set = (i_ap_done && (r_state != RUN)) ||
                       (w_done_acc && w_fifo_empty && !w_issue_acc);

  ap_ts_fifo #(
    .DEPTH (DEPTH),
    .W     (CNT_W)
  ) u_ts_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clr   (w_clear),
    .i_push  (w_fifo_push),
    .i_data  (r_run_cycles),
    .i_pop   (w_fifo_pop),
    .o_data  (w_fifo_q),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ap_start  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_cmd_start) w_state_nxt = (i_cmd_num != '0) ? RUN : FINISH;
      end
      RUN: begin
        w_ap_start = (r_issued < r_num) && !w_fifo_full;
        if (w_last) w_state_nxt = FINISH;
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_num        <= '0;
      r_issued     <= '0;
      r_completed  <= '0;
      r_run_cycles <= '0;
      r_lat_min    <= '1;
      r_lat_max    <= '0;
      r_proto_err  <= 1'b0;
    end else if (w_clear) begin
      r_num        <= i_cmd_num;
      r_issued     <= '0;
      r_completed  <= '0;
      r_run_cycles <= '0;
      r_lat_min    <= '1;
      r_lat_max    <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      if (w_issue_acc) r_issued    <= r_issued + NUM_W'(1);
      if (w_done_acc)  r_completed <= r_completed + NUM_W'(1);
      if (w_lat_vld) begin
        if (w_lat < r_lat_min) r_lat_min <= w_lat;
        if (w_lat > r_lat_max) r_lat_max <= w_lat;
      end
      if (r_state == RUN) r_run_cycles <= CNT_W'(sat_inc(64'(r_run_cycles), CNT_W));
      if (w_proto_set) r_proto_err <= 1'b1;
    end
  end

  assign o_ap_start    = w_ap_start;
  assign o_ap_continue = w_ap_continue;
  assign o_busy        = (r_state != IDLE);
  assign o_run_done    = (r_state == FINISH);
  assign o_issued      = r_issued;
  assign o_completed   = r_completed;
  assign o_run_cycles  = r_run_cycles;
  assign o_lat_min     = r_lat_min;
  assign o_lat_max     = r_lat_max;
  assign o_proto_err   = r_proto_err;

endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// Directed bench for ap_ctrl_hs_driver: a small behavioural kernel answers ap_start
// with a fixed latency and capacity; expected statistics are hand-computed per scenario.
module tb_ap_ctrl_hs_driver;

  localparam int NUM_W = 16;
  localparam int CNT_W = 32;
  localparam int DEPTH = 4;
`ifdef AP_CTRL_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             i_reset;
  logic             i_cmd_start;
  logic [NUM_W-1:0] i_cmd_num;
  logic             o_ap_start;
  logic             i_ap_ready;
  logic             i_ap_done;
  logic             o_ap_continue;
  logic             i_cont_allow;
  logic             o_busy;
  logic             o_run_done;
  logic [NUM_W-1:0] o_issued;
  logic [NUM_W-1:0] o_completed;
  logic [CNT_W-1:0] o_run_cycles;
  logic [CNT_W-1:0] o_lat_min;
  logic [CNT_W-1:0] o_lat_max;
  logic             o_proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ap_ctrl_hs_driver #(.NUM_W(NUM_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_cmd_start   (i_cmd_start),
    .i_cmd_num     (i_cmd_num),
    .o_ap_start    (o_ap_start),
    .i_ap_ready    (i_ap_ready),
    .i_ap_done     (i_ap_done),
    .o_ap_continue (o_ap_continue),
    .i_cont_allow  (i_cont_allow),
    .o_busy        (o_busy),
    .o_run_done    (o_run_done),
    .o_issued      (o_issued),
    .o_completed   (o_completed),
    .o_run_cycles  (o_run_cycles),
    .o_lat_min     (o_lat_min),
    .o_lat_max     (o_lat_max),
    .o_proto_err   (o_proto_err)
  );

  // Starts a run and plays a kernel with latency lat (0 = combinational) and
  // capacity cap. Returns in the cycle run_done is seen (cycle index fin_cyc).
  task automatic run_kernel(input logic [NUM_W-1:0] num, input int lat, input int cap,
                            input int cont_on, input int inject_cyc, input int probe_cyc,
                            output int max_infl, output int n_start_hi, output int probe_val,
                            output int fin_cyc, output bit timed_out);
    int due[$];
    int infl;
    bit rdy, dn, cont;
    infl = 0; max_infl = 0; n_start_hi = 0; probe_val = -1; fin_cyc = -1; timed_out = 1'b1;
    i_cmd_start = 1'b1;
    i_cmd_num   = num;
    @(posedge clk); #1;
    i_cmd_start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (o_run_done) begin
        fin_cyc = cyc;
        timed_out = 1'b0;
        break;
      end
      if (cyc == probe_cyc) probe_val = int'(o_completed);
      if (cyc == inject_cyc) begin i_cmd_start = 1'b1; i_cmd_num = 16'd7; end
      else i_cmd_start = 1'b0;
      i_cont_allow = (cyc >= cont_on);
      if (o_ap_start) n_start_hi++;
      if (lat == 0) begin
        rdy = o_ap_start;
        dn  = o_ap_start;
      end else begin
        rdy = o_ap_start && (infl < cap);
        dn  = (due.size() > 0) && (due[0] <= cyc);
      end
      i_ap_ready = rdy;
      i_ap_done  = dn;
      cont = CHAIN ? i_cont_allow : 1'b1;
      if (lat > 0) begin
        if (rdy) begin due.push_back(cyc + lat); infl++; end
        if (dn && cont) begin due.delete(0); infl--; end
        if (infl > max_infl) max_infl = infl;
      end
      @(posedge clk); #1;
    end
    i_ap_ready = 1'b0; i_ap_done = 1'b0; i_cmd_start = 1'b0; i_cont_allow = 1'b1;
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_cmd_start = 1'b0; i_cmd_num = '0;
    i_ap_ready = 1'b0; i_ap_done = 1'b0; i_cont_allow = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_ap_start !== 1'b0) begin errors++; $display("FAIL reset ap_start: got %b want 0", o_ap_start); end
    checks++; if (o_ap_continue !== (CHAIN ? 1'b0 : 1'b1)) begin errors++; $display("FAIL reset ap_continue: got %b want %b", o_ap_continue, !CHAIN); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", o_busy); end
    checks++; if (o_run_done !== 1'b0) begin errors++; $display("FAIL reset run_done: got %b want 0", o_run_done); end
    checks++; if (o_issued !== 16'd0 || o_completed !== 16'd0) begin errors++; $display("FAIL reset counts: got issued=%0d completed=%0d want 0/0", o_issued, o_completed); end
    checks++; if (o_run_cycles !== 32'd0) begin errors++; $display("FAIL reset run_cycles: got %0d want 0", o_run_cycles); end
    checks++; if (o_lat_min !== 32'hFFFF_FFFF || o_lat_max !== 32'd0) begin errors++; $display("FAIL reset lat: got min=%h max=%h want ffffffff/0", o_lat_min, o_lat_max); end
    checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL reset proto_err: got %b want 0", o_proto_err); end
    @(negedge clk); i_reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int mi, ns, pv, fc; bit to;
    run_kernel(16'd3, 2, 1, 0, 1, -1, mi, ns, pv, fc, to);
    checks++; if (to) begin errors++; $display("FAIL single timeout: no run_done within budget"); end
    checks++; if (fc !== 9) begin errors++; $display("FAIL single finish cycle: got %0d want 9", fc); end
    checks++; if (o_issued !== 16'd3 || o_completed !== 16'd3) begin errors++; $display("FAIL single counts: got %0d/%0d want 3/3", o_issued, o_completed); end
    checks++; if (o_lat_min !== 32'd2 || o_lat_max !== 32'd2) begin errors++; $display("FAIL single lat: got min=%0d max=%0d want 2/2", o_lat_min, o_lat_max); end
    checks++; if (o_run_cycles !== 32'd9) begin errors++; $display("FAIL single run_cycles: got %0d want 9", o_run_cycles); end
    checks++; if (o_proto_err !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL single flags: got proto=%b busy=%b want 0/1", o_proto_err, o_busy); end
    @(posedge clk); #1;
    checks++; if (o_run_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL single pulse: got run_done=%b busy=%b want 0/0", o_run_done, o_busy); end
    checks++; if (o_issued !== 16'd3 || o_lat_max !== 32'd2) begin errors++; $display("FAIL single hold: got issued=%0d lat_max=%0d want 3/2", o_issued, o_lat_max); end
  endtask

  task automatic test_zero();
    int mi, ns, pv, fc; bit to;
    run_kernel(16'd0, 2, 1, 0, -1, -1, mi, ns, pv, fc, to);
    checks++; if (to || fc !== 0) begin errors++; $display("FAIL zero finish: got cycle=%0d timeout=%b want 0/0", fc, to); end
    checks++; if (ns !== 0) begin errors++; $display("FAIL zero ap_start: got %0d high cycles want 0", ns); end
    @(posedge clk); #1;
    checks++; if (o_busy !== 1'b0 || o_run_done !== 1'b0) begin errors++; $display("FAIL zero idle: got busy=%b run_done=%b want 0/0", o_busy, o_run_done); end
  endtask

  task automatic test_pipelined();
    int mi, ns, pv, fc; bit to;
    run_kernel(16'd8, 10, 16, 0, -1, -1, mi, ns, pv, fc, to);
    checks++; if (to || fc !== 25) begin errors++; $display("FAIL pipe finish: got cycle=%0d timeout=%b want 25/0", fc, to); end
    checks++; if (mi !== 4) begin errors++; $display("FAIL pipe outstanding: got %0d want 4", mi); end
    checks++; if (o_issued !== 16'd8 || o_completed !== 16'd8) begin errors++; $display("FAIL pipe counts: got %0d/%0d want 8/8", o_issued, o_completed); end
    checks++; if (o_lat_min !== 32'd10 || o_lat_max !== 32'd10) begin errors++; $display("FAIL pipe lat: got min=%0d max=%0d want 10/10", o_lat_min, o_lat_max); end
    checks++; if (o_run_cycles !== 32'd25) begin errors++; $display("FAIL pipe run_cycles: got %0d want 25", o_run_cycles); end
    @(posedge clk); #1;
  endtask

  task automatic test_comb();
    int mi, ns, pv, fc; bit to;
    run_kernel(16'd5, 0, 1, 0, -1, -1, mi, ns, pv, fc, to);
    checks++; if (to || fc !== 5) begin errors++; $display("FAIL comb finish: got cycle=%0d timeout=%b want 5/0", fc, to); end
    checks++; if (o_completed !== 16'd5 || o_issued !== 16'd5) begin errors++; $display("FAIL comb counts: got %0d/%0d want 5/5", o_issued, o_completed); end
    checks++; if (o_lat_min !== 32'd0 || o_lat_max !== 32'd0) begin errors++; $display("FAIL comb lat: got min=%0d max=%0d want 0/0", o_lat_min, o_lat_max); end
    checks++; if (o_run_cycles !== 32'd5 || o_proto_err !== 1'b0) begin errors++; $display("FAIL comb run: got cycles=%0d proto=%b want 5/0", o_run_cycles, o_proto_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_spurious_idle();
    int mi, ns, pv, fc; bit to;
    i_ap_done = 1'b1;
    @(posedge clk); #1;
    i_ap_done = 1'b0;
    checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL idle done proto_err: got %b want 1", o_proto_err); end
    run_kernel(16'd2, 0, 1, 0, -1, -1, mi, ns, pv, fc, to);
    checks++; if (to || o_proto_err !== 1'b0) begin errors++; $display("FAIL idle clear proto_err: got %b timeout=%b want 0/0", o_proto_err, to); end
    @(posedge clk); #1;
  endtask

  task automatic test_proto_run();
    i_cmd_start = 1'b1; i_cmd_num = 16'd2;
    @(posedge clk); #1;
    i_cmd_start = 1'b0;
    i_ap_ready = 1'b0; i_ap_done = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_proto_err !== 1'b1 || o_completed !== 16'd1) begin errors++; $display("FAIL run orphan done: got proto=%b completed=%0d want 1/1", o_proto_err, o_completed); end
    i_ap_ready = 1'b1; i_ap_done = 1'b1;
    @(posedge clk); #1;
    i_ap_ready = 1'b0; i_ap_done = 1'b0;
    checks++; if (o_run_done !== 1'b1 || o_issued !== 16'd1 || o_completed !== 16'd2) begin errors++; $display("FAIL run orphan end: got run_done=%b issued=%0d completed=%0d want 1/1/2", o_run_done, o_issued, o_completed); end
    checks++; if (o_lat_min !== 32'd0 || o_lat_max !== 32'd0 || o_proto_err !== 1'b1) begin errors++; $display("FAIL run orphan lat: got min=%0d max=%0d proto=%b want 0/0/1", o_lat_min, o_lat_max, o_proto_err); end
    @(posedge clk); #1;
  endtask

  // ap_done held from cycle 2; cont_allow low until cycle 8 (ignored without chain).
  task automatic test_chain();
    int mi, ns, pv, fc; bit to;
    run_kernel(16'd1, 2, 1, 8, -1, 2, mi, ns, pv, fc, to);
    checks++; if (to || fc !== (CHAIN ? 9 : 3)) begin errors++; $display("FAIL chain finish: got cycle=%0d timeout=%b want %0d", fc, to, CHAIN ? 9 : 3); end
    checks++; if (pv !== 0) begin errors++; $display("FAIL chain stall completed: got %0d want 0", pv); end
    checks++; if (o_completed !== 16'd1) begin errors++; $display("FAIL chain completed: got %0d want 1", o_completed); end
    checks++; if (o_lat_max !== (CHAIN ? 32'd8 : 32'd2) || o_run_cycles !== (CHAIN ? 32'd9 : 32'd3)) begin errors++; $display("FAIL chain lat: got lat=%0d cycles=%0d", o_lat_max, o_run_cycles); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    int mi, ns, pv, fc; bit to;
    i_cmd_start = 1'b1; i_cmd_num = 16'd4;
    @(posedge clk); #1;
    i_cmd_start = 1'b0; i_ap_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    i_ap_ready = 1'b0;
    checks++; if (o_issued !== 16'd2 || o_busy !== 1'b1) begin errors++; $display("FAIL midrun pre: got issued=%0d busy=%b want 2/1", o_issued, o_busy); end
    #2 i_reset = 1'b0;
    #1;
    checks++; if (o_ap_start !== 1'b0 || o_busy !== 1'b0 || o_issued !== 16'd0 || o_run_cycles !== 32'd0) begin errors++; $display("FAIL midrun async: got start=%b busy=%b issued=%0d cycles=%0d want 0", o_ap_start, o_busy, o_issued, o_run_cycles); end
    checks++; if (o_lat_min !== 32'hFFFF_FFFF || o_lat_max !== 32'd0 || o_ap_continue !== (CHAIN ? 1'b0 : 1'b1)) begin errors++; $display("FAIL midrun lat: got min=%h max=%0d cont=%b", o_lat_min, o_lat_max, o_ap_continue); end
    @(posedge clk);
    @(negedge clk); i_reset = 1'b1;
    @(posedge clk); #1;
    run_kernel(16'd3, 2, 1, 0, -1, -1, mi, ns, pv, fc, to);
    checks++; if (to || o_issued !== 16'd3 || o_completed !== 16'd3) begin errors++; $display("FAIL midrun rerun: got %0d/%0d timeout=%b want 3/3/0", o_issued, o_completed, to); end
    checks++; if (o_lat_max !== 32'd2 || o_run_cycles !== 32'd9) begin errors++; $display("FAIL midrun rerun stats: got lat=%0d cycles=%0d want 2/9", o_lat_max, o_run_cycles); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_pipelined();
    test_comb();
    test_spurious_idle();
    test_proto_run();
    test_chain();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_hs_driver.md
Name: ap_ctrl_hs_driver

Overview:
- Synthesizable initiator for the ap_ctrl_hs block-level handshake: drives ap_start into an HLS kernel (e.g. spmv) and consumes ap_ready/ap_done.
- Issues a programmed number of back-to-back transactions and allows up to DEPTH of them outstanding, for pipelined kernels where ap_ready precedes ap_done.
- Measures per-transaction latency and total run time, and reports min, max and total counts.
- Used in on-board and self-checking benches in place of the testbench-driven start sequence.

Parameters:
- NUM_W, 16, width of transaction count.
- CNT_W, 32, width of cycle/latency counters.
- DEPTH, 4, maximum outstanding transactions (power of 2, >=1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- cmd_start  in  1  one-cycle pulse; begin a run.
- cmd_num  in  NUM_W  transactions to issue; sampled on cmd_start.
- ap_start  out  1  to kernel.
- ap_ready  in  1  from kernel.
- ap_done  in  1  from kernel.
- ap_continue  out  1  to kernel.
- cont_allow  in  1  completion acceptance; used only with AP_CTRL_CHAIN_EN.
- busy  out  1  run in progress.
- run_done  out  1  one-cycle pulse at end of run.
- issued  out  NUM_W  accepted starts this run.
- completed  out  NUM_W  accepted dones this run.
- run_cycles  out  CNT_W  cycles from first RUN cycle to last done, saturating.
- lat_min  out  CNT_W  minimum latency.
- lat_max  out  CNT_W  maximum latency.
- proto_err  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - ap_start=0, ap_continue=0 (1 if macro absent), busy=0, run_done=0, proto_err=0.
  - issued, completed, run_cycles = 0; lat_min = all ones; lat_max = 0.
  - FSM = IDLE; timestamp FIFO empty.
  - Reset asserted mid-run aborts immediately; no drain.
- FSM states: IDLE, RUN, FINISH.
  - IDLE: on cmd_start with cmd_num>0, latch cmd_num, clear all statistics and proto_err, empty FIFO, go to RUN.
  - IDLE with cmd_num=0: go to FINISH; no ap_start is ever raised.
  - cmd_start is ignored outside IDLE.
  - RUN: when completed reaches latched num (including an accept in the current cycle), go to FINISH next cycle.
  - FINISH: run_done=1 for exactly one cycle, then IDLE. Statistics hold until the next accepted cmd_start.
- busy is high in RUN and FINISH.
- ap_start:
  - Combinational from registers only: (state==RUN) && issued<num && !fifo_full.
  - Issue accept = ap_start && ap_ready.
  - On accept: issued++, and push the current run_cycles value as a timestamp.
  - ap_start stays high across cycles while ap_ready=0; it never drops without an accept unless the FIFO is full.
- Done accept = ap_done && ap_continue, in RUN only.
  - Pop the oldest timestamp.
  - Latency = run_cycles − popped timestamp, CNT_W unsigned.
  - Update lat_min/lat_max; completed++.
- Same-cycle issue and done accept: push and pop both occur.
  - If the FIFO is empty, bypass: latency=0 and the FIFO stays empty.
- ap_done accepted with FIFO empty and no same-cycle issue:
  - proto_err=1 (sticky until next run).
  - completed still increments, latency not updated.
- ap_done in IDLE or FINISH: proto_err=1.
- run_cycles:
  - Increments every RUN cycle.
  - Saturates at all ones, and timestamps saturate with it.
  - Latency at saturation is unreliable and is not flagged.
- Latency per transaction is 0 for combinational kernels, otherwise cycles between the issue and done accepts.

Optional Feature:
- Macro AP_CTRL_CHAIN_EN.
  - Defined: ap_continue = cont_allow && (state==RUN). This exercises ap_ctrl_chain backpressure; a held ap_done is counted once, in the cycle ap_continue is high.
  - Undefined: ap_continue is tied to 1 and cont_allow is ignored.

Decomposition:
- Package ap_ctrl_pkg holds:
  - FSM state enum {IDLE, RUN, FINISH};
  - localparam defaults for NUM_W, CNT_W, DEPTH;
  - a function for the saturating increment.
- Sub-module ap_ts_fifo: synchronous FIFO, DEPTH x CNT_W, with push/pop/full/empty and same-cycle push+pop support. Its reset is the same asynchronous active-low reset.

Test Plan:
- cmd_num=3, kernel ready=done 2 cycles after start, non-pipelined → issued=3, completed=3, lat_min=lat_max=2, one run_done pulse, proto_err=0.
- DEPTH=4, cmd_num=8, ready same cycle as start, done 10 cycles later → ap_start drops after 4 outstanding; all 8 complete; lat_max=10.
- Combinational kernel (ready=done=ap_start), cmd_num=5 → lat_min=lat_max=0 via bypass, run_cycles=5.
- Spurious ap_done while idle → proto_err=1; the next cmd_start clears it.
- With AP_CTRL_CHAIN_EN: cont_allow=0 for 6 cycles while ap_done is held, cmd_num=1 → completed stays 0 until cont_allow=1, then 1; latency includes the stall.
- Reset pulled low mid-run (issued=2 of 4) → all outputs return to reset values asynchronously; a subsequent run behaves normally.
